key_expand_multi: RTL and testbench
===================================

Name: key_expand_multi

Overview:
- Parametrised key expander for the AES decryption core; covers FIPS-197 key lengths of 128, 192 and 256 bits, selected per key at run time.
- Generates the full schedule one 32-bit word per cycle into an internal roundkey store.
- Plays the roundkeys out with a valid/ready handshake, in forward order (encrypt) or reverse order (decrypt).
- The stored schedule can be replayed without re-expansion. Sits between the key interface and the round datapath.

Parameters:
- MAX_NK, 8, largest supported Nk (4, 6 or 8). Sets kt width usage and store depth.
- NUM_RK, MAX_NK+7 (localparam), number of roundkey store entries (Nr+1 for the largest key).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- kt  in  256  key, [0:255] big-endian. 128-bit key in kt[0:127]; 192-bit key in kt[0:191]; unused bits ignored.
- klen  in  2  0 = 128, 1 = 192, 2 = 256, 3 = illegal. Sampled with kt.
- dir  in  1  0 = forward (round 0 first), 1 = reverse (round Nr first). Sampled at key accept or replay.
- kt_vld  in  1  new key present.
- kt_rdy  out  1  key accepted when kt_vld & kt_rdy.
- replay  in  1  single-cycle request to replay the stored schedule.
- key_err  out  1  one-cycle pulse when a key with unsupported klen is consumed.
- rkey  out  128  current roundkey [0:127].
- rkey_idx  out  4  round number of rkey (0..Nr).
- rkey_vld  out  1  rkey valid.
- rkey_rdy  in  1  consumer accepts rkey.
- rkey_last  out  1  high with the final roundkey of a playout.

Behaviour:
- Reset (rst=0 at an edge): state IDLE. kt_rdy=1; rkey_vld=0, rkey_last=0, key_err=0; rkey=0, rkey_idx=0; stored schedule marked invalid. Reset mid-EXPAND or mid-PLAY aborts immediately, with no further outputs.
- States: IDLE, EXPAND, PLAY, READY. kt_rdy=1 only in IDLE and READY.
- Key accept (IDLE/READY, kt_vld=1): klen legal and Nk≤MAX_NK → latch Nk, Nr=Nk+6 and dir, load the 8-word window, go to EXPAND. Otherwise pulse key_err next cycle, consume the key, keep the current state; a valid stored schedule is retained.
- EXPAND: one cycle per word i = 0 .. 4(Nr+1)-1.
  - i < Nk: w[i] = key word i.
  - Otherwise w[i] = w[i-Nk] ^ temp.
  - temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk],24'h0} when i mod Nk = 0.
  - temp = SubWord(w[i-1]) when Nk = 8 and i mod Nk = 4.
  - Else temp = w[i-1].
  - Every 4th word writes store entry i/4. After the last word go to PLAY.
- Latency: with the accept edge at cycle 0, rkey_vld first rises at cycle 4(Nr+1)+2, i.e. cycle 46 / 54 / 62 for 128 / 192 / 256.
- PLAY: index starts at 0 (dir=0) or Nr (dir=1) and steps ±1 on each rkey_vld & rkey_rdy.
  - rkey, rkey_idx, rkey_vld and rkey_last are registered. They are held stable while rkey_vld & !rkey_rdy. The next entry is prefetched, so back-to-back handshakes give one roundkey per cycle.
  - rkey_last=1 for index Nr (forward) or 0 (reverse). On its handshake go to READY with rkey_vld=0 the next cycle.
- READY: schedule valid.
  - replay=1 → sample dir and go to PLAY. First rkey_vld arrives 2 cycles later.
  - replay and kt_vld in the same cycle: kt_vld wins and replay is dropped.
  - replay in IDLE, EXPAND or PLAY is ignored.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. Only indices up to 4(Nr+1)/Nk are used.
- kt_vld outside IDLE/READY is not accepted; the source must hold it until kt_rdy.

Decomposition:
- Shared package aes_pkg holds:
  - klen_t enum (K128, K192, K256).
  - nk_of()/nr_of() functions.
  - RCON constant array.
  - SBOX constant and sub_word() function, reused by the existing SubWord datapath.
- One sub-module, rkey_store: NUM_RK×128 single-write, single-registered-read store with write index, read index and read enable. Expansion FSM, word window and playout counter stay in key_expand_multi.

Test Plan:
- 128-bit forward: kt[0:127]=2b7e151628aed2a6abf7158809cf4f3c, klen=0, dir=0, rkey_rdy=1 → rkey_vld rises at cycle 46. Idx0 equals the key. Idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rkey_last=1. Eleven consecutive valid cycles.
- 192-bit reverse: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, dir=1 → first rkey idx12 = e98ba06f448c773c8ecc720401002202. Last rkey idx0 = 8e73b0f7da0e6452c810f32b809079e5 with rkey_last.
- 256-bit with backpressure: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, rkey_rdy toggled 1010… → rkey stable while stalled. Idx14 = fe4890d1e6188d0b046df344706c631e. Exactly 15 handshakes.
- Replay and error: in READY, pulse replay with dir=1 → identical 11 keys, reversed, with no re-expansion (rkey_vld 2 cycles after replay). Then klen=3 with kt_vld → key_err pulse, state stays READY, replay still works.
- Simultaneous events: kt_vld and replay in the same READY cycle → new key expanded, replay dropped. kt_vld during PLAY → kt_rdy=0 and key held until READY.
- Reset mid-operation: rst=0 at cycle 20 of EXPAND → next cycle rkey_vld=0, kt_rdy=1. A subsequent replay is ignored. A fresh 128-bit key plays correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule: key-length encoding, Nk/Nr lookup,
// round constants, the forward S-box and the SubWord helper.
package aes_pkg;

  typedef enum logic [1:0] {
    K128 = 2'd0,
    K192 = 2'd1,
    K256 = 2'd2
  } klen_t;

  // Rcon[1..10] of FIPS-197, stored from index 0.
  localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Nk in words; 0 flags an unsupported length.
  function automatic logic [3:0] nk_of(input logic [1:0] klen);
    case (klen)
      K128:    return 4'd4;
      K192:    return 4'd6;
      K256:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] klen);
    return nk_of(klen) + 4'd6;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/key_expand_multi_if.sv
// Key-side and roundkey-side handshake bundle of the key expander.
//   kt/klen/dir/kt_vld -> kt_rdy : key load, kt is [0:255] big-endian
//   replay                       : replay the stored schedule
//   key_err                      : unsupported key length consumed
//   rkey/rkey_idx/rkey_vld/rkey_last -> rkey_rdy : roundkey playout
// master = key source / roundkey consumer, slave = key_expand_multi.
interface key_expand_multi_if;
  logic [0:255] kt;
  logic [1:0]   klen;
  logic         dir;
  logic         kt_vld;
  logic         kt_rdy;
  logic         replay;
  logic         key_err;
  logic [0:127] rkey;
  logic [3:0]   rkey_idx;
  logic         rkey_vld;
  logic         rkey_rdy;
  logic         rkey_last;

  modport master (
    output kt, klen, dir, kt_vld, replay, rkey_rdy,
    input  kt_rdy, key_err, rkey, rkey_idx, rkey_vld, rkey_last
  );

  modport slave (
    input  kt, klen, dir, kt_vld, replay, rkey_rdy,
    output kt_rdy, key_err, rkey, rkey_idx, rkey_vld, rkey_last
  );
endinterface

// File: rtl/rkey_store.sv
// Roundkey store: one write port, one registered read port.
//   clk, rst    : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata : write one 128-bit roundkey
//   re/raddr/rdata : rdata loads mem[raddr] on cycles with re, holds otherwise
module rkey_store #(
  parameter int unsigned Depth = 15,
  parameter int unsigned Aw    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [Aw-1:0] waddr,
  input  logic [127:0]  wdata,
  input  logic          re,
  input  logic [Aw-1:0] raddr,
  output logic [127:0]  rdata
);
  logic [127:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/key_expand_multi.sv
// Run-time selectable AES-128/192/256 key expander with roundkey playout.
//   clk, rst : clock, synchronous active-low reset
//   bus      : key_expand_multi_if.slave (key load, replay, roundkey stream)
// One schedule word is produced per cycle into rkey_store; the stored schedule is
// then streamed forward or reversed and may be replayed without re-expansion.
module key_expand_multi
  import aes_pkg::*;
#(
  parameter int unsigned MAX_NK = 8
) (
  input logic               clk,
  input logic               rst,
  key_expand_multi_if.slave bus
);
  localparam int unsigned NUM_RK = MAX_NK + 7;

  typedef enum logic [1:0] {StIdle, StExpand, StPlay, StReady} state_e;

  state_e       state_q, state_d;
  logic [3:0]   nk_q, nr_q;
  logic         dir_q;
  logic [31:0]  win_q [8];  // circular buffer, word i lives at i mod 8
  logic [5:0]   wi_q;
  logic [2:0]   mod_q;      // i mod Nk
  logic [3:0]   rc_q;
  logic         key_err_q;
  logic [3:0]   ptr_q;
  logic         fetch_done_q;
  logic         s1_vld_q, s1_last_q;
  logic [3:0]   s1_idx_q;
  logic [127:0] rkey_q;
  logic [3:0]   idx_q;
  logic         vld_q, last_q;

  logic         kt_rdy, accept, key_ok, load, start_replay, enter_play, play_dir;
  logic [3:0]   klen_nk, end_idx, ptr_next;
  logic [2:0]   prev_ptr, back_ptr, m2_ptr, m3_ptr;
  logic [31:0]  w_prev, temp, w_new;
  logic         last_word, we;
  logic [127:0] wdata, rdata;
  logic         out_take, fetch, hs;

  always_comb begin
    kt_rdy       = (state_q == StIdle) || (state_q == StReady);
    klen_nk      = nk_of(bus.klen);
    key_ok       = (klen_nk != 4'd0) && (klen_nk <= 4'(MAX_NK));
    accept       = bus.kt_vld && kt_rdy;
    load         = accept && key_ok;
    // A key offered in the same cycle takes precedence over replay.
    start_replay = (state_q == StReady) && bus.replay && !bus.kt_vld;

    prev_ptr = wi_q[2:0] - 3'd1;
    m2_ptr   = wi_q[2:0] - 3'd2;
    m3_ptr   = wi_q[2:0] - 3'd3;
    back_ptr = wi_q[2:0] - nk_q[2:0];
    w_prev   = win_q[prev_ptr];
    temp     = w_prev;
    if (mod_q == 3'd0) begin
      temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {RCON[rc_q], 24'h0};
    end else if ((nk_q == 4'd8) && (mod_q == 3'd4)) begin
      temp = sub_word(w_prev);
    end
    if (wi_q < {2'b00, nk_q}) w_new = win_q[wi_q[2:0]];
    else                      w_new = win_q[back_ptr] ^ temp;

    last_word  = (wi_q == {nr_q, 2'b11});
    we         = (state_q == StExpand) && (wi_q[1:0] == 2'b11);
    wdata      = {win_q[m3_ptr], win_q[m2_ptr], w_prev, w_new};
    enter_play = ((state_q == StExpand) && last_word) || start_replay;
    play_dir   = start_replay ? bus.dir : dir_q;

    end_idx  = dir_q ? 4'd0 : nr_q;
    ptr_next = dir_q ? (ptr_q - 4'd1) : (ptr_q + 4'd1);
    hs       = vld_q && bus.rkey_rdy;
    // Output stage refills when empty or draining; the read stage refills behind it.
    out_take = s1_vld_q && (!vld_q || bus.rkey_rdy);
    fetch    = (state_q == StPlay) && !fetch_done_q && (!s1_vld_q || out_take);

    state_d = state_q;
    case (state_q)
      StIdle:   if (load) state_d = StExpand;
      StExpand: if (last_word) state_d = StPlay;
      StPlay:   if (hs && last_q) state_d = StReady;
      StReady: begin
        if (load)              state_d = StExpand;
        else if (start_replay) state_d = StPlay;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      nk_q         <= 4'd4;
      nr_q         <= 4'd10;
      dir_q        <= 1'b0;
      wi_q         <= '0;
      mod_q        <= '0;
      rc_q         <= '0;
      key_err_q    <= 1'b0;
      ptr_q        <= '0;
      fetch_done_q <= 1'b1;
      s1_vld_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_idx_q     <= '0;
      rkey_q       <= '0;
      idx_q        <= '0;
      vld_q        <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_err_q <= accept && !key_ok;

      if (load) begin
        nk_q  <= klen_nk;
        nr_q  <= nr_of(bus.klen);
        dir_q <= bus.dir;
        wi_q  <= '0;
        mod_q <= '0;
        rc_q  <= '0;
      end else if (state_q == StExpand) begin
        wi_q  <= wi_q + 6'd1;
        mod_q <= (mod_q == (nk_q[2:0] - 3'd1)) ? 3'd0 : (mod_q + 3'd1);
        if ((mod_q == 3'd0) && (wi_q >= {2'b00, nk_q})) rc_q <= rc_q + 4'd1;
      end
      if (start_replay) dir_q <= bus.dir;

      if (enter_play) begin
        ptr_q        <= play_dir ? nr_q : 4'd0;
        fetch_done_q <= 1'b0;
      end else if (fetch) begin
        ptr_q <= ptr_next;
        if (ptr_q == end_idx) fetch_done_q <= 1'b1;
      end

      if (fetch) begin
        s1_vld_q  <= 1'b1;
        s1_idx_q  <= ptr_q;
        s1_last_q <= (ptr_q == end_idx);
      end else if (out_take) begin
        s1_vld_q <= 1'b0;
      end

      if (out_take) begin
        rkey_q <= rdata;
        idx_q  <= s1_idx_q;
        vld_q  <= 1'b1;
        last_q <= s1_last_q;
      end else if (hs) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < 8; j++) win_q[j] <= bus.kt[32*j +: 32];
    end else if (state_q == StExpand) begin
      win_q[wi_q[2:0]] <= w_new;
    end
  end

  rkey_store #(
    .Depth(NUM_RK),
    .Aw   (4)
  ) u_store (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(wi_q[5:2]),
    .wdata(wdata),
    .re   (fetch),
    .raddr(ptr_q),
    .rdata(rdata)
  );

  assign bus.kt_rdy    = kt_rdy;
  assign bus.key_err   = key_err_q;
  assign bus.rkey      = rkey_q;
  assign bus.rkey_idx  = idx_q;
  assign bus.rkey_vld  = vld_q;
  assign bus.rkey_last = last_q;
endmodule

// File: tb/tb_key_expand_multi.sv
// Self-checking bench for key_expand_multi: FIPS-197 vectors, random keys,
// backpressure, replay, illegal length, simultaneous events and mid-expand reset.
module tb_key_expand_multi;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_expand_multi_if bus ();

  key_expand_multi #(.MAX_NK(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]   sb [256];
  logic [7:0]   rc [11];
  logic [0:127] exp_rk [15];
  logic [0:127] got_rk [15];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_tables();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int j = 2; j < 11; j++) rc[j] = gmul(rc[j-1], 8'h02);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model(input logic [0:255] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk], 24'h0};
        else if (nk == 8 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [0:255] rand_key();
    logic [0:255] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  task automatic send_key(input logic [0:255] key, input logic [1:0] kl, input logic d);
    int n;
    n = 0;
    bus.kt = key; bus.klen = kl; bus.dir = d; bus.kt_vld = 1'b1;
    while (!bus.kt_rdy && n < 300) begin step(); n++; end
    if (n >= 300) chk("kt_rdy_wait", 128'(bus.kt_rdy), 128'd1);
    step();
    bus.kt_vld = 1'b0;
  endtask

  task automatic wait_vld(output int cyc);
    cyc = 0;
    while (!bus.rkey_vld && cyc < 300) begin step(); cyc++; end
  endtask

  // mode 0: always ready, 1: ready 1010..., 2: random ready
  task automatic play_check(input int nr, input logic d, input int mode, input string tag);
    int exp_idx, hs, cyc;
    logic stalled, hl;
    logic [127:0] hk;
    logic [3:0] hi;
    exp_idx = d ? nr : 0;
    hs = 0; cyc = 0; stalled = 1'b0;
    hk = '0; hi = '0; hl = 1'b0;
    while (hs < nr + 1 && cyc < 400) begin
      case (mode)
        0:       bus.rkey_rdy = 1'b1;
        1:       bus.rkey_rdy = (cyc % 2 == 0);
        default: bus.rkey_rdy = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        chk({tag, "_hold_vld"}, 128'(bus.rkey_vld), 128'd1);
        chk({tag, "_hold_key"}, bus.rkey, hk);
        chk({tag, "_hold_idx_last"}, 128'({bus.rkey_idx, bus.rkey_last}), 128'({hi, hl}));
      end
      if (bus.rkey_vld && bus.rkey_rdy) begin
        chk({tag, "_idx"}, 128'(bus.rkey_idx), 128'(exp_idx));
        chk({tag, "_key"}, bus.rkey, exp_rk[exp_idx]);
        chk({tag, "_last"}, 128'(bus.rkey_last), 128'(hs == nr));
        got_rk[exp_idx] = bus.rkey;
        hs++;
        exp_idx = d ? exp_idx - 1 : exp_idx + 1;
      end
      stalled = bus.rkey_vld && !bus.rkey_rdy;
      hk = bus.rkey; hi = bus.rkey_idx; hl = bus.rkey_last;
      step();
      cyc++;
    end
    chk({tag, "_handshakes"}, 128'(hs), 128'(nr + 1));
    chk({tag, "_vld_after_last"}, 128'(bus.rkey_vld), 128'd0);
    if (mode == 0) chk({tag, "_cycles"}, 128'(cyc), 128'(nr + 1));
    bus.rkey_rdy = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:255] key, kb;
    logic [1:0] kl, klb;
    logic d;
    int cyc, nk, nkb;
    logic seen;

    build_tables();
    rst = 1'b0;
    bus.kt = '0; bus.klen = 2'd0; bus.dir = 1'b0; bus.kt_vld = 1'b0;
    bus.replay = 1'b0; bus.rkey_rdy = 1'b1;
    step(); step(); step();

    // Reset state
    chk("rst_kt_rdy", 128'(bus.kt_rdy), 128'd1);
    chk("rst_rkey_vld", 128'(bus.rkey_vld), 128'd0);
    chk("rst_rkey_last", 128'(bus.rkey_last), 128'd0);
    chk("rst_key_err", 128'(bus.key_err), 128'd0);
    chk("rst_rkey", bus.rkey, 128'd0);
    chk("rst_rkey_idx", 128'(bus.rkey_idx), 128'd0);
    rst = 1'b1;
    step();

    // AES-128 forward
    key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    model(key, 4);
    send_key(key, 2'd0, 1'b0);
    chk("k128_key_err", 128'(bus.key_err), 128'd0);
    wait_vld(cyc);
    chk("k128_latency", 128'(cyc), 128'd46);
    play_check(10, 1'b0, 0, "k128");
    chk("k128_idx0_is_key", got_rk[0], key[0:127]);
    chk("k128_idx10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Replay reversed, no re-expansion
    bus.dir = 1'b1; bus.replay = 1'b1;
    step();
    bus.replay = 1'b0;
    wait_vld(cyc);
    chk("replay_latency", 128'(cyc), 128'd2);
    play_check(10, 1'b1, 0, "replay_rev");

    // Illegal length: error pulse, stays READY, replay still works
    send_key(rand_key(), 2'd3, 1'b0);
    chk("illegal_key_err", 128'(bus.key_err), 128'd1);
    chk("illegal_kt_rdy", 128'(bus.kt_rdy), 128'd1);
    step();
    chk("illegal_key_err_pulse", 128'(bus.key_err), 128'd0);
    bus.dir = 1'b0; bus.replay = 1'b1;
    step();
    bus.replay = 1'b0;
    wait_vld(cyc);
    chk("replay2_latency", 128'(cyc), 128'd2);
    play_check(10, 1'b0, 0, "replay_fwd");

    // AES-192 reverse
    key = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    model(key, 6);
    send_key(key, 2'd1, 1'b1);
    wait_vld(cyc);
    chk("k192_latency", 128'(cyc), 128'd54);
    play_check(12, 1'b1, 0, "k192");
    chk("k192_idx12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("k192_idx0", got_rk[0], 128'h8e73b0f7da0e6452c810f32b809079e5);

    // AES-256 forward with 1010 backpressure
    key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    model(key, 8);
    send_key(key, 2'd2, 1'b0);
    wait_vld(cyc);
    chk("k256_latency", 128'(cyc), 128'd62);
    play_check(14, 1'b0, 1, "k256_bp");
    chk("k256_idx14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // kt_vld and replay together in READY: key wins
    key = rand_key(); kl = 2'($urandom_range(0, 2)); d = 1'($urandom_range(0, 1));
    nk = 4 + 2 * int'(kl);
    model(key, nk);
    bus.kt = key; bus.klen = kl; bus.dir = d; bus.kt_vld = 1'b1; bus.replay = 1'b1;
    step();
    bus.kt_vld = 1'b0; bus.replay = 1'b0;
    wait_vld(cyc);
    chk("simul_latency", 128'(cyc), 128'(4 * (nk + 7) + 2));
    play_check(nk + 6, d, 0, "simul");

    // kt_vld during PLAY is held off until READY
    key = rand_key(); kl = 2'($urandom_range(0, 2));
    nk = 4 + 2 * int'(kl);
    model(key, nk);
    send_key(key, kl, 1'b0);
    wait_vld(cyc);
    kb = rand_key(); klb = 2'($urandom_range(0, 2));
    nkb = 4 + 2 * int'(klb);
    bus.kt = kb; bus.klen = klb; bus.dir = 1'b1; bus.kt_vld = 1'b1;
    chk("play_kt_rdy", 128'(bus.kt_rdy), 128'd0);
    play_check(nk + 6, 1'b0, 2, "held_a");
    chk("ready_kt_rdy", 128'(bus.kt_rdy), 128'd1);
    step();
    bus.kt_vld = 1'b0;
    model(kb, nkb);
    wait_vld(cyc);
    chk("held_b_latency", 128'(cyc), 128'(4 * (nkb + 7) + 2));
    play_check(nkb + 6, 1'b1, 2, "held_b");

    // Random keys, lengths, directions and backpressure, each with a replay
    for (int it = 0; it < 6; it++) begin
      key = rand_key(); kl = 2'($urandom_range(0, 2)); d = 1'($urandom_range(0, 1));
      nk = 4 + 2 * int'(kl);
      model(key, nk);
      send_key(key, kl, d);
      wait_vld(cyc);
      chk("rand_latency", 128'(cyc), 128'(4 * (nk + 7) + 2));
      play_check(nk + 6, d, 2, "rand");
      d = 1'($urandom_range(0, 1));
      bus.dir = d; bus.replay = 1'b1;
      step();
      bus.replay = 1'b0;
      wait_vld(cyc);
      chk("rand_replay_latency", 128'(cyc), 128'd2);
      play_check(nk + 6, d, 2, "rand_replay");
    end

    // Reset in the middle of expansion
    send_key(rand_key(), 2'd2, 1'b0);
    for (int k = 0; k < 20; k++) step();
    rst = 1'b0;
    step();
    chk("midrst_rkey_vld", 128'(bus.rkey_vld), 128'd0);
    chk("midrst_kt_rdy", 128'(bus.kt_rdy), 128'd1);
    rst = 1'b1;
    step();
    bus.replay = 1'b1;
    step();
    bus.replay = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.rkey_vld) seen = 1'b1;
      step();
    end
    chk("midrst_replay_ignored", 128'(seen), 128'd0);
    chk("midrst_idle_kt_rdy", 128'(bus.kt_rdy), 128'd1);
    key = rand_key();
    model(key, 4);
    send_key(key, 2'd0, 1'b0);
    wait_vld(cyc);
    chk("midrst_k128_latency", 128'(cyc), 128'd46);
    play_check(10, 1'b0, 0, "midrst_k128");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
